// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared definitions for the reg_file_2r1w register file.
//   - state_t        : clear-engine states (CLEAR, IDLE)
//   - DEFAULT_DATA_W : default entry / data-port width
//   - DEFAULT_ADDR_W : default address width (DEPTH = 2**ADDR_W)
// Optional feature macro used by the top: REG_BYPASS_EN.
package reg_file_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

endpackage : reg_file_pkg

// File: rtl/reg_file_clear_fsm.sv
// reg_file_clear_fsm: sequential clear engine for the register file.
// Walks every entry from 0 to DEPTH-1, one per clock, requesting a zero
// write to each. Entered from reset and on a clear request; a clear request
// while already clearing restarts the walk from entry 0.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset (forces CLEAR, count 0)
//   clear_req  in   one-cycle request to restart the clear
//   busy       out  high while the clear walk is in progress
//   wipe_en    out  zero-write strobe for the array
//   wipe_addr  out  entry being zeroed this cycle
//   state      out  current engine state (debug / checker visibility)
module reg_file_clear_fsm
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req,
  output logic              busy,
  output logic              wipe_en,
  output logic [ADDR_W-1:0] wipe_addr,
  output state_t            state
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] count_q, count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      CLEAR: begin
        if (clear_req) begin
          count_d = '0;
        end else if (count_q == LAST) begin
          // This edge zeroes the last entry; the array is usable afterwards.
          state_d = IDLE;
          count_d = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          count_d = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        count_d = '0;
      end
    endcase
  end

  assign busy      = (state_q == CLEAR);
  assign wipe_en   = (state_q == CLEAR);
  assign wipe_addr = count_q;
  assign state     = state_q;

endmodule : reg_file_clear_fsm

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: clocked MIPS register file, two registered read ports and
// one synchronous write port. Entry 0 always reads as zero. A clear engine
// zeroes every entry after reset and on REG_clear; while it runs the array
// is inaccessible, writes are dropped and read outputs are held at zero.
// Build option: define REG_BYPASS_EN for write-first behaviour on a
// same-edge write/read of one non-zero address; otherwise read-first.
// Ports:
//   clk, rst_n          clock / asynchronous active-low reset
//   REG_clear           one-cycle request to zero the array
//   REG_busy            clear in progress
//   REG_rd_en           read strobe for both read ports
//   REG_address1/2      read addresses
//   REG_write_1         write enable
//   REG_address_wr      write address
//   REG_data_wr_in1     write data
//   REG_data_out1/2     registered read data
//
// Handshake: no valid/ready; an access is accepted on a rising edge only
// when REG_busy is low at that edge and REG_clear is not asserted (clear
// wins over a same-cycle write). Read data appears one edge later and holds
// until the next accepted read.
module reg_file_2r1w
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              REG_clear,
  output logic              REG_busy,
  input  logic              REG_rd_en,
  input  logic [ADDR_W-1:0] REG_address1,
  input  logic [ADDR_W-1:0] REG_address2,
  input  logic              REG_write_1,
  input  logic [ADDR_W-1:0] REG_address_wr,
  input  logic [DATA_W-1:0] REG_data_wr_in1,
  output logic [DATA_W-1:0] REG_data_out1,
  output logic [DATA_W-1:0] REG_data_out2
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            fsm_state;
  logic              wipe_en;
  logic [ADDR_W-1:0] wipe_addr;
  logic              idle;
  logic              wr_ok;
  logic [DATA_W-1:0] rd1, rd2;

  reg_file_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_req (REG_clear),
    .busy      (REG_busy),
    .wipe_en   (wipe_en),
    .wipe_addr (wipe_addr),
    .state     (fsm_state)
  );

  assign idle  = (fsm_state == IDLE);
  // Writes to entry 0 are discarded so it never holds anything but zero.
  assign wr_ok = idle && !REG_clear && REG_write_1 && (REG_address_wr != '0);

  // The array needs no reset: the clear engine zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (wipe_en) begin
      mem[wipe_addr] <= '0;
    end else if (wr_ok) begin
      mem[REG_address_wr] <= REG_data_wr_in1;
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (REG_address1 != '0) begin
`ifdef REG_BYPASS_EN
      rd1 = (wr_ok && (REG_address_wr == REG_address1)) ? REG_data_wr_in1
                                                        : mem[REG_address1];
`else
      rd1 = mem[REG_address1];
`endif
    end
    if (REG_address2 != '0) begin
`ifdef REG_BYPASS_EN
      rd2 = (wr_ok && (REG_address_wr == REG_address2)) ? REG_data_wr_in1
                                                        : mem[REG_address2];
`else
      rd2 = mem[REG_address2];
`endif
    end
  end

  // Outputs are zeroed on the edge that starts a clear so they read 0 for
  // the whole busy window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      REG_data_out1 <= '0;
      REG_data_out2 <= '0;
    end else if (!idle || REG_clear) begin
      REG_data_out1 <= '0;
      REG_data_out2 <= '0;
    end else if (REG_rd_en) begin
      REG_data_out1 <= rd1;
      REG_data_out2 <= rd2;
    end
  end

endmodule : reg_file_2r1w

// File: tb/tb_reg_file_2r1w.sv
module tb_reg_file_2r1w;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
  localparam int RW     = 2 * DATA_W + 1;

`ifdef REG_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              REG_clear = 1'b0;
  logic              REG_busy;
  logic              REG_rd_en = 1'b0;
  logic [ADDR_W-1:0] REG_address1 = '0;
  logic [ADDR_W-1:0] REG_address2 = '0;
  logic              REG_write_1 = 1'b0;
  logic [ADDR_W-1:0] REG_address_wr = '0;
  logic [DATA_W-1:0] REG_data_wr_in1 = '0;
  logic [DATA_W-1:0] REG_data_out1;
  logic [DATA_W-1:0] REG_data_out2;

  always #5 clk = ~clk;

  reg_file_2r1w #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .REG_clear       (REG_clear),
    .REG_busy        (REG_busy),
    .REG_rd_en       (REG_rd_en),
    .REG_address1    (REG_address1),
    .REG_address2    (REG_address2),
    .REG_write_1     (REG_write_1),
    .REG_address_wr  (REG_address_wr),
    .REG_data_wr_in1 (REG_data_wr_in1),
    .REG_data_out1   (REG_data_out1),
    .REG_data_out2   (REG_data_out2)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [RW-1:0] exp_q[$];

  // Reference model: architectural contents, remaining busy cycles, outputs.
  logic [DATA_W-1:0] model_mem [DEPTH];
  int                busy_left;
  logic [DATA_W-1:0] m_out1, m_out2;

  task automatic check(input string name, input logic [RW-1:0] act,
                       input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got busy=%0b o1=%08h o2=%08h, expected busy=%0b o1=%08h o2=%08h",
               name, act[RW-1], act[2*DATA_W-1:DATA_W], act[DATA_W-1:0],
               exp[RW-1], exp[2*DATA_W-1:DATA_W], exp[DATA_W-1:0]);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_read(
      input logic [ADDR_W-1:0] a, input logic wr, input logic [ADDR_W-1:0] wa,
      input logic [DATA_W-1:0] wd);
    if (a == 0) return '0;
    if (BYPASS && wr && wa == a) return wd;
    return model_mem[a];
  endfunction

  task automatic model_wipe();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    m_out1 = '0;
    m_out2 = '0;
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [RW-1:0] e;
      e = exp_q.pop_front();
      check("cycle", {REG_busy, REG_data_out1, REG_data_out2}, e);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge: applies inputs for the next rising edge, steps
  // the model across that edge, queues the expectation, then waits.
  task automatic step(input logic clr, input logic wr, input logic [ADDR_W-1:0] wa,
                      input logic [DATA_W-1:0] wd, input logic rd,
                      input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2);
    REG_clear       = clr;
    REG_write_1     = wr;
    REG_address_wr  = wa;
    REG_data_wr_in1 = wd;
    REG_rd_en       = rd;
    REG_address1    = a1;
    REG_address2    = a2;
    if (clr) begin
      model_wipe();
      busy_left = DEPTH;
    end else if (busy_left > 0) begin
      busy_left--;
      m_out1 = '0;
      m_out2 = '0;
    end else begin
      if (rd) begin
        m_out1 = model_read(a1, wr, wa, wd);
        m_out2 = model_read(a2, wr, wa, wd);
      end
      if (wr && wa != 0) model_mem[wa] = wd;
    end
    exp_q.push_back({busy_left > 0, m_out1, m_out2});
    @(negedge clk);
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic rand_step(input bit allow_clear);
    step(allow_clear && ($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
         ADDR_W'($urandom_range(0, DEPTH - 1)), $urandom,
         1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, DEPTH - 1)),
         ADDR_W'($urandom_range(0, DEPTH - 1)));
  endtask

  // Asynchronous reset mid-cycle; returns at a falling edge with rst_n high.
  task automatic do_reset(input string name);
    #2;
    rst_n = 1'b0;
    #1;
    check(name, {REG_busy, REG_data_out1, REG_data_out2}, {1'b1, {2*DATA_W{1'b0}}});
    model_wipe();
    busy_left = DEPTH;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_wipe();
    busy_left = DEPTH;
    #1;
    check("reset_values", {REG_busy, REG_data_out1, REG_data_out2},
          {1'b1, {2*DATA_W{1'b0}}});
    @(negedge clk);
    rst_n = 1'b1;

    // Busy for exactly DEPTH cycles; accesses attempted meanwhile are ignored.
    for (int i = 0; i < DEPTH; i++) rand_step(1'b0);
    for (int i = 1; i < DEPTH; i++) step(1'b0, 1'b0, '0, '0, 1'b1, ADDR_W'(i), ADDR_W'(DEPTH - i));

    // Write then dual read of the same entry.
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 5'd5, 5'd5);
    idle_step();

    // Entry 0 stays zero.
    step(1'b0, 1'b1, 5'd0, 32'h12345678, 1'b0, '0, '0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 5'd5);

    // Same-edge write/read collision, then the follow-up read.
    step(1'b0, 1'b1, 5'd7, 32'h11111111, 1'b0, '0, '0);
    step(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b1, 5'd7, 5'd7);
    step(1'b0, 1'b0, '0, '0, 1'b1, 5'd7, 5'd0);
    idle_step();

    // Clear with concurrent write (dropped), restart at cycle 10.
    step(1'b0, 1'b1, 5'd3, 32'h01020304, 1'b0, '0, '0);
    step(1'b1, 1'b1, 5'd3, 32'hFFFFFFFF, 1'b1, 5'd3, 5'd5);
    for (int i = 0; i < 9; i++) rand_step(1'b0);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    for (int i = 0; i < DEPTH; i++) rand_step(1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 5'd3, 5'd7);

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 400; i++) rand_step(1'b1);
    while (busy_left > 0) rand_step(1'b0);

    // Reset in the middle of a clear.
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    for (int i = 0; i < 5; i++) rand_step(1'b0);
    do_reset("reset_mid_clear");
    for (int i = 0; i < DEPTH; i++) rand_step(1'b0);
    step(1'b0, 1'b1, 5'd9, 32'hCAFEF00D, 1'b0, '0, '0);

    // Reset right after a read has produced non-zero data.
    step(1'b0, 1'b0, '0, '0, 1'b1, 5'd9, 5'd9);
    do_reset("reset_mid_read");
    for (int i = 0; i < DEPTH; i++) rand_step(1'b0);
    for (int i = 0; i < 100; i++) rand_step(1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_reg_file_2r1w
